// File: rtl/softmc_pkg.sv
// Shared SoftMC definitions used by the instruction-sequence loader.
//   OPC_END / opcode field : marks the end of a host instruction sequence
//   INSTR_NOP              : filler word used to complete an instruction pair
//   loader_state_e         : iseq_loader FSM states
package softmc_pkg;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;

  localparam logic [3:0]  OPC_END   = 4'b1111;
  localparam logic [31:0] INSTR_NOP = 32'h1000_0000;

  typedef enum logic [2:0] {
    LOAD,
    PAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } loader_state_e;

  function automatic logic is_end_instr(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_END;
  endfunction

endpackage

// File: rtl/iseq_loader.sv
// iseq_loader: producer side of the instruction-sequence path.
// Host words are written alternately into the instr0/instr1 FIFOs. An END
// word is consumed, the sequence is padded to an even pair, the dispatcher is
// started with a one-cycle process_iseq pulse and the loader waits for
// dispatcher_busy to fall before accepting the next sequence.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   app_instr_*         : host word stream (valid/ready handshake)
//   instr0_fifo_*       : slot-0 FIFO write port and full flag
//   instr1_fifo_*       : slot-1 FIFO write port and full flag
//   process_iseq        : one-cycle dispatcher start pulse
//   dispatcher_busy     : registered busy flag from the dispatcher
//   loader_busy         : high outside the LOAD state
//   iseq_done           : one-cycle pulse when a sequence completes
//   instr_count         : host words written in the current sequence
//
// Optional feature: define ISEQ_LOADER_STREAM_EN to start the dispatcher
// early when instr0 fills during loading, allowing sequences longer than the
// FIFO depth.
module iseq_loader
  import softmc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 app_instr_valid,
  input  logic [31:0]          app_instr_data,
  output logic                 app_instr_ready,
  output logic                 instr0_fifo_wr,
  output logic [31:0]          instr0_fifo_data,
  input  logic                 instr0_fifo_full,
  output logic                 instr1_fifo_wr,
  output logic [31:0]          instr1_fifo_data,
  input  logic                 instr1_fifo_full,
  output logic                 process_iseq,
  input  logic                 dispatcher_busy,
  output logic                 loader_busy,
  output logic                 iseq_done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  loader_state_e        state;
  logic                 slot;
  logic [CNT_WIDTH-1:0] count;

  logic fire;
  logic word_is_end;
  logic load_wr;
  logic pad_wr;
  logic stream_go;
  logic seq_started;

  assign word_is_end = is_end_instr(app_instr_data);

  assign app_instr_ready = ~rst & (state == LOAD) &
                           ~(slot ? instr1_fifo_full : instr0_fifo_full);

  assign fire    = app_instr_valid & app_instr_ready;
  assign load_wr = fire & ~word_is_end;
  assign pad_wr  = ~rst & (state == PAD) & ~instr1_fifo_full;

  assign instr0_fifo_wr   = load_wr & ~slot;
  assign instr0_fifo_data = instr0_fifo_wr ? app_instr_data : '0;

  assign instr1_fifo_wr   = (load_wr & slot) | pad_wr;
  assign instr1_fifo_data = pad_wr            ? INSTR_NOP      :
                            (load_wr & slot)  ? app_instr_data : '0;

  assign loader_busy = (state != LOAD);
  assign instr_count = count;

`ifdef ISEQ_LOADER_STREAM_EN
  // The dispatcher is kicked at most once per sequence; seq_started also
  // covers the cycle in which the kick is being issued, so an END seen in
  // that same cycle does not produce a second start.
  logic started;

  assign stream_go   = (state == LOAD) & ~started & instr0_fifo_full &
                       ~dispatcher_busy & (count != '0);
  assign seq_started = started | stream_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      started <= 1'b0;
    end else if ((state == WAIT_DONE) && !dispatcher_busy) begin
      started <= 1'b0;
    end else if (stream_go) begin
      started <= 1'b1;
    end
  end
`else
  assign stream_go   = 1'b0;
  assign seq_started = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      slot         <= 1'b0;
      count        <= '0;
      process_iseq <= 1'b0;
      iseq_done    <= 1'b0;
    end else begin
      process_iseq <= 1'b0;
      iseq_done    <= 1'b0;

      if (instr0_fifo_wr || instr1_fifo_wr) begin
        slot <= ~slot;
      end
      if (load_wr) begin
        count <= count + CNT_ONE;
      end

      unique case (state)
        LOAD: begin
          if (stream_go) begin
            process_iseq <= 1'b1;
          end
          if (fire && word_is_end) begin
            if (slot) begin
              state <= PAD;
            end else if (count != '0) begin
              if (seq_started) begin
                state <= WAIT_DONE;
              end else begin
                state        <= START;
                process_iseq <= 1'b1;
              end
            end else begin
              // Empty sequence: nothing to dispatch, complete immediately.
              iseq_done <= 1'b1;
            end
          end
        end

        PAD: begin
          if (!instr1_fifo_full) begin
            if (seq_started) begin
              state <= WAIT_DONE;
            end else begin
              state        <= START;
              process_iseq <= 1'b1;
            end
          end
        end

        START: begin
          state <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (dispatcher_busy) begin
            state <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (!dispatcher_busy) begin
            iseq_done <= 1'b1;
            count     <= '0;
            slot      <= 1'b0;
            state     <= LOAD;
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iseq_loader.sv
// Scoreboard bench for iseq_loader: stimulus pushes expected FIFO words and
// expected pulse cycles into queues, a negedge monitor pops and compares.
module tb_iseq_loader;

  localparam logic [31:0] END_W = 32'hF000_0000;
  localparam logic [31:0] NOP_W = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        app_instr_valid = 1'b0;
  logic [31:0] app_instr_data = '0;
  logic        app_instr_ready;
  logic        instr0_fifo_wr, instr1_fifo_wr;
  logic [31:0] instr0_fifo_data, instr1_fifo_data;
  logic        instr0_fifo_full, instr1_fifo_full;
  logic        process_iseq, dispatcher_busy, loader_busy, iseq_done;
  logic [15:0] instr_count;

  logic tb_full0 = 1'b0;
  logic tb_full1 = 1'b0;
  logic stream_phase = 1'b0;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int unsigned exp_proc[$];
  int unsigned exp_done[$];
  bit bslot = 1'b0;

  // Dispatcher model for directed tests: busy for 4 cycles after the pulse.
  logic       f_busy;
  logic [2:0] f_cnt;
  // Dispatcher/FIFO model for the streaming test: depth-16 FIFOs drained
  // one pair every third cycle.
  logic       s_busy;
  int         occ0, occ1;
  int         pop_div;
  logic       pop;
  int unsigned s_proc_cnt = 0;
  int unsigned s_done_cnt = 0;

  assign instr0_fifo_full = tb_full0 | (stream_phase && occ0 >= 16);
  assign instr1_fifo_full = tb_full1 | (stream_phase && occ1 >= 16);
  assign dispatcher_busy  = stream_phase ? s_busy : f_busy;
  assign pop = s_busy && occ0 > 0 && occ1 > 0 && pop_div == 0;

  iseq_loader #(.CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .app_instr_valid  (app_instr_valid),
    .app_instr_data   (app_instr_data),
    .app_instr_ready  (app_instr_ready),
    .instr0_fifo_wr   (instr0_fifo_wr),
    .instr0_fifo_data (instr0_fifo_data),
    .instr0_fifo_full (instr0_fifo_full),
    .instr1_fifo_wr   (instr1_fifo_wr),
    .instr1_fifo_data (instr1_fifo_data),
    .instr1_fifo_full (instr1_fifo_full),
    .process_iseq     (process_iseq),
    .dispatcher_busy  (dispatcher_busy),
    .loader_busy      (loader_busy),
    .iseq_done        (iseq_done),
    .instr_count      (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      f_busy <= 1'b0;
      f_cnt  <= '0;
    end else if (process_iseq) begin
      f_busy <= 1'b1;
      f_cnt  <= 3'd3;
    end else if (f_cnt != 0) begin
      f_cnt <= f_cnt - 3'd1;
    end else begin
      f_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst || !stream_phase) begin
      s_busy  <= 1'b0;
      occ0    <= 0;
      occ1    <= 0;
      pop_div <= 0;
    end else begin
      occ0    <= occ0 + int'(instr0_fifo_wr) - int'(pop);
      occ1    <= occ1 + int'(instr1_fifo_wr) - int'(pop);
      pop_div <= (pop_div == 2) ? 0 : pop_div + 1;
      if (process_iseq) s_busy <= 1'b1;
      else if (s_busy && occ0 == 0 && occ1 == 0 && loader_busy) s_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: compares every FIFO write and every start/done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr0_fifo_wr) begin
        if (exp0.size() == 0) fail_chk("fifo0 unexpected write", instr0_fifo_data, '0);
        else chk("fifo0 data", instr0_fifo_data, exp0.pop_front());
      end else begin
        chk("fifo0 idle data", instr0_fifo_data, '0);
      end
      if (instr1_fifo_wr) begin
        if (exp1.size() == 0) fail_chk("fifo1 unexpected write", instr1_fifo_data, '0);
        else chk("fifo1 data", instr1_fifo_data, exp1.pop_front());
      end else begin
        chk("fifo1 idle data", instr1_fifo_data, '0);
      end
      if (stream_phase) begin
        if (process_iseq) s_proc_cnt++;
        if (iseq_done) s_done_cnt++;
      end else begin
        if (process_iseq || (exp_proc.size() != 0 && exp_proc[0] == cyc)) begin
          if (exp_proc.size() == 0) fail_chk("process_iseq unexpected", cyc, '0);
          else chk("process_iseq cycle", process_iseq ? cyc : 0, exp_proc.pop_front());
        end
        if (iseq_done || (exp_done.size() != 0 && exp_done[0] == cyc)) begin
          if (exp_done.size() == 0) fail_chk("iseq_done unexpected", cyc, '0);
          else chk("iseq_done cycle", iseq_done ? cyc : 0, exp_done.pop_front());
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    if (bslot) exp1.push_back(w);
    else exp0.push_back(w);
    bslot = ~bslot;
  endtask

  task automatic send(input logic [31:0] w, output int unsigned acc);
    bit got;
    got = 1'b0;
    acc = 0;
    app_instr_valid = 1'b1;
    app_instr_data  = w;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (app_instr_ready) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!got) fail_chk("handshake timeout", 32'(app_instr_ready), 32'd1);
    @(posedge clk); #1;
    app_instr_valid = 1'b0;
    app_instr_data  = '0;
  endtask

  // n host words then END; returns at the negedge of the cycle after END.
  task automatic run_seq(input int n, input logic [31:0] base, input bit track_done);
    int unsigned a, e, p;
    bslot = 1'b0;
    for (int i = 0; i < n; i++) begin
      push_word(base + 32'(i));
      send(base + 32'(i), a);
    end
    send(END_W, e);
    if (bslot) begin
      exp1.push_back(NOP_W);
      p = e + 2;
    end else begin
      p = e + 1;
    end
    if (n == 0) begin
      exp_done.push_back(e + 1);
    end else begin
      exp_proc.push_back(p);
      if (track_done) exp_done.push_back(p + 6);
    end
    @(negedge clk);
    chk("instr_count after END", 32'(instr_count), 32'(n));
    chk("loader_busy after END", 32'(loader_busy), 32'(n != 0));
    bslot = 1'b0;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned a, e;
    // Reset: ready must stay low even with a valid word offered.
    app_instr_valid = 1'b1;
    app_instr_data  = 32'hA000_0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready during rst", 32'(app_instr_ready), 32'd0);
    chk("fifo0 wr during rst", 32'(instr0_fifo_wr), 32'd0);
    app_instr_valid = 1'b0;
    app_instr_data  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset loader_busy", 32'(loader_busy), 32'd0);
    chk("reset instr_count", 32'(instr_count), 32'd0);
    chk("reset process_iseq", 32'(process_iseq), 32'd0);
    chk("reset iseq_done", 32'(iseq_done), 32'd0);
    @(posedge clk); #1;

    // 4 words: even, no padding.
    run_seq(4, 32'hA000_0000, 1'b1);
    settle();
    chk("idle after 4-word seq", 32'(loader_busy), 32'd0);
    chk("count cleared after seq", 32'(instr_count), 32'd0);

    // 3 words: padded with NOP into instr1.
    run_seq(3, 32'hB000_0010, 1'b1);
    settle();

    // END only: empty sequence.
    run_seq(0, 32'h0, 1'b1);
    settle();

    // instr1 full for 5 cycles while slot=1.
    bslot = 1'b0;
    push_word(32'hC000_0001);
    send(32'hC000_0001, a);
    tb_full1 = 1'b1;
    push_word(32'hC000_0002);
    app_instr_valid = 1'b1;
    app_instr_data  = 32'hC000_0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ready while instr1 full", 32'(app_instr_ready), 32'd0);
    end
    @(posedge clk); #1;
    tb_full1 = 1'b0;
    @(negedge clk);
    chk("ready on release", 32'(app_instr_ready), 32'd1);
    chk("instr1 write on release", 32'(instr1_fifo_wr), 32'd1);
    @(posedge clk); #1;
    app_instr_valid = 1'b0;
    app_instr_data  = '0;
    send(END_W, e);
    exp_proc.push_back(e + 1);
    exp_done.push_back(e + 7);
    @(negedge clk);
    chk("instr_count after stall seq", 32'(instr_count), 32'd2);
    bslot = 1'b0;
    settle();

    // Reset while in WAIT_DONE, then a normal 2-word sequence.
    run_seq(2, 32'hD000_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("loader_busy in WAIT_DONE", 32'(loader_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    app_instr_valid = 1'b1;
    app_instr_data  = 32'hD000_00FF;
    @(negedge clk);
    chk("ready during mid rst", 32'(app_instr_ready), 32'd0);
    chk("fifo1 wr during mid rst", 32'(instr1_fifo_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    app_instr_valid = 1'b0;
    app_instr_data  = '0;
    @(negedge clk);
    chk("loader_busy after mid rst", 32'(loader_busy), 32'd0);
    chk("instr_count after mid rst", 32'(instr_count), 32'd0);
    chk("iseq_done after mid rst", 32'(iseq_done), 32'd0);
    @(posedge clk); #1;
    run_seq(2, 32'hE000_0000, 1'b1);
    settle();

`ifdef ISEQ_LOADER_STREAM_EN
    // 40 words into depth-16 FIFOs with an early dispatcher start.
    stream_phase = 1'b1;
    @(posedge clk); #1;
    bslot = 1'b0;
    for (int i = 0; i < 40; i++) begin
      push_word(32'h2000_0100 + 32'(i));
      send(32'h2000_0100 + 32'(i), a);
    end
    send(END_W, e);
    @(negedge clk);
    chk("stream instr_count", 32'(instr_count), 32'd40);
    for (int n = 0; n < 2000 && s_done_cnt == 0; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("stream process_iseq pulses", s_proc_cnt, 32'd1);
    chk("stream iseq_done pulses", s_done_cnt, 32'd1);
    stream_phase = 1'b0;
    bslot = 1'b0;
    settle();
`endif

    chk("fifo0 words outstanding", 32'(exp0.size()), 32'd0);
    chk("fifo1 words outstanding", 32'(exp1.size()), 32'd0);
    chk("process pulses outstanding", 32'(exp_proc.size()), 32'd0);
    chk("done pulses outstanding", 32'(exp_done.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iseq_loader.md
# iseq_loader

Producer side of the instruction-sequence path. It accepts 32-bit DRAM instruction words from the host stream and distributes them alternately into the instr0/instr1 FIFOs. On the END instruction it pads to an even pair, pulses `process_iseq` to start the instruction-sequence dispatcher, and tracks the dispatcher's `dispatcher_busy` until the sequence drains. It sits between the host application interface and the two instruction FIFOs in the SoftMC top level.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the loaded-word counter.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset; synchronous, active-high, one clock domain.
- `app_instr_valid`  in  1: host word valid.
- `app_instr_data`  in  32: host instruction word.
- `app_instr_ready`  out  1: word accepted when valid & ready.
- `instr0_fifo_wr`  out  1: write strobe, slot-0 FIFO.
- `instr0_fifo_data`  out  32: slot-0 write data.
- `instr0_fifo_full`  in  1: slot-0 FIFO full.
- `instr1_fifo_wr`, `instr1_fifo_data`, `instr1_fifo_full`: same as the slot-0 ports, for the slot-1 FIFO.
- `process_iseq`  out  1: one-cycle start pulse to the dispatcher.
- `dispatcher_busy`  in  1: registered busy from the dispatcher.
- `loader_busy`  out  1: high in every state except LOAD.
- `iseq_done`  out  1: one-cycle pulse when the sequence completes.
- `instr_count`  out  CNT_WIDTH: count of host words written to the FIFOs in the current sequence. Excludes END and padding.

## Operation
- FSM states: LOAD (reset state), PAD, START, WAIT_BUSY, WAIT_DONE.
- `slot` register, reset value 0. It selects the target FIFO for the next word and toggles on every FIFO write.
- LOAD behaviour:
  - `app_instr_ready = ~full[slot]`.
  - An accepted non-END word is written combinationally: `instrN_fifo_wr = valid & ready & (slot==N)`, with data passed through.
  - Each such write increments `instr_count` (wraps modulo 2^CNT_WIDTH).
- END detection: a word is END when `app_instr_data[31:28] == OPC_END`. END is consumed (ready follows the same rule) and is never written to a FIFO.
- END transitions from LOAD:
  - END with slot=1 → PAD.
  - END with slot=0 and count>0 → START.
  - END with slot=0 and count=0 (empty sequence) → LOAD, `iseq_done` pulses next cycle, `process_iseq` is never asserted.
- PAD: writes `INSTR_NOP` to instr1 in the first cycle that `instr1_fifo_full` is 0, then → START.
- START: `process_iseq`=1 for exactly one cycle, → WAIT_BUSY.
- WAIT_BUSY: → WAIT_DONE when `dispatcher_busy`=1.
- WAIT_DONE: when `dispatcher_busy`=0, `iseq_done` pulses, `instr_count` clears, `slot` clears, → LOAD.
- `app_instr_ready`=0 in every state except LOAD.
- Reset mid-operation: the FSM returns to LOAD and all outputs and counters clear in the cycle following `rst`. FIFO contents are not touched by this block.

## Timing
- Reset values: `app_instr_ready`=0 during rst; `instr0_fifo_wr`, `instr1_fifo_wr`, `process_iseq`, `loader_busy`, `iseq_done` = 0; `instr_count`=0; FIFO data outputs = 0 when their write strobe is low.
- Latency: host word to FIFO write is 0 cycles (same cycle as the handshake).
- Last word to `process_iseq` is 1 cycle, or 2 cycles when padding is needed and instr1 is not full.
- `dispatcher_busy` rises 1 cycle after `process_iseq`, so WAIT_BUSY normally lasts 1 cycle.
- `iseq_done` is asserted in the cycle after `dispatcher_busy` is sampled low in WAIT_DONE.
- A full FIFO stalls acceptance with no data loss; the word is held by the host.

## Configuration
- Macro `ISEQ_LOADER_STREAM_EN`.
- Defined: in LOAD, if both FIFOs are non-empty-capable and `instr0_fifo_full` is seen while `dispatcher_busy`=0, `process_iseq` pulses once per sequence (sticky `started` flag) and loading continues. At END, START is skipped (already started) and the FSM proceeds to WAIT_DONE after padding. This allows sequences longer than the FIFO depth.
- Not defined: a full FIFO simply stalls. Sequences must fit in the FIFOs, otherwise the loader stalls indefinitely by design.

## Structure
- Shared package `softmc_pkg`: `OPC_END` (4'b1111), `INSTR_NOP` (32-bit NOP encoding), the opcode field position [31:28], and the loader FSM state enum.
- No sub-module is required. The FSM, slot toggle and counter are kept in one module.

## Test plan
- 4 words A,B,C,D then END → instr0 receives A,C; instr1 receives B,D; `process_iseq` pulses 1 cycle after END; `instr_count`=4; `iseq_done` pulses after the model drops busy.
- 3 words then END → instr1 gets `INSTR_NOP` as its second entry; `instr_count`=3; `process_iseq` pulses 2 cycles after END.
- END only → no FIFO writes, no `process_iseq`, `iseq_done` pulses 1 cycle later, `instr_count`=0.
- `instr1_fifo_full` held for 5 cycles while slot=1 → `app_instr_ready`=0 for those 5 cycles, the word is written on the release cycle, and nothing is dropped or duplicated.
- `rst` asserted in WAIT_DONE → next cycle state is LOAD, slot=0, count=0, `iseq_done` not pulsed; a following 2-word sequence completes normally.
- With `ISEQ_LOADER_STREAM_EN`, 40 words into depth-16 FIFOs → a single `process_iseq` pulse when instr0 fills, all 40 words delivered in order, `iseq_done` pulses once.
